// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM datapath: controller states, default
// fixed-point format and the accumulator sizing rule.
package lstm_pkg;

  // Controller states of the gate pre-activation MAC
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    ROUND = 3'd3,
    OUT   = 3'd4
  } state_e;

  // Default data format Q(WL-FL).FL
  localparam int DEF_WL = 16;
  localparam int DEF_FL = 8;

  // Smallest accumulator that holds bias<<FL plus N full-scale products
  // without overflow (one product is 2*WL bits, N of them add clog2(N)
  // bits, and one more covers the bias term and the rounding constant).
  function automatic int acc_min_wl(input int wl, input int n);
    return 2 * wl + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/round_sat.sv
// Round-half-up and saturate a wide signed accumulator to a WL-bit word.
// Purely combinational; reused wherever a wide sum returns to data width.
module round_sat #(
  parameter int ACC_WL = 40,
  parameter int WL     = 16,
  parameter int FL     = 8
) (
  input  logic signed [ACC_WL-1:0] acc,
  output logic signed [WL-1:0]     out_data,
  output logic                     out_sat
);

  // Half an LSB of the output format; zero when there is nothing to drop
  localparam logic signed [ACC_WL-1:0] RND = ACC_WL'((64'd1 << FL) >> 1);

  // Output range limits expressed at accumulator width
  localparam logic signed [ACC_WL-1:0] SAT_MAX =
    $signed({{(ACC_WL-WL+1){1'b0}}, {(WL-1){1'b1}}});
  localparam logic signed [ACC_WL-1:0] SAT_MIN =
    $signed({{(ACC_WL-WL+1){1'b1}}, {(WL-1){1'b0}}});

  logic signed [ACC_WL-1:0] biased;
  logic signed [ACC_WL-1:0] shifted;

  // Add half an LSB, shift arithmetically, then clip to the WL range
  always_comb begin
    biased   = acc + RND;
    shifted  = biased >>> FL;
    out_data = shifted[WL-1:0];
    out_sat  = 1'b0;
    if (shifted > SAT_MAX) begin
      out_data = SAT_MAX[WL-1:0];
      out_sat  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      out_data = SAT_MIN[WL-1:0];
      out_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/gate_preact_mac.sv
// LSTM gate pre-activation engine: bias + sum(x[i]*w[i]) over N pairs,
// one pair per cycle, followed by round/saturate and a valid/ready result.
module gate_preact_mac
  import lstm_pkg::*;
#(
  parameter int WL     = DEF_WL,
  parameter int FL     = DEF_FL,
  parameter int N      = 8,
  parameter int ACC_WL = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [WL-1:0] bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [WL-1:0] x_in,
  input  logic signed [WL-1:0] w_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [WL-1:0] out_data,
  output logic                 out_sat,
  output logic                 busy
);

  localparam int PROD_W = 2 * WL;
  localparam int CNT_W  = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Refuse to build an accumulator that could overflow
  if (ACC_WL < acc_min_wl(WL, N)) begin : g_acc_wl_check
    $error("gate_preact_mac: ACC_WL=%0d below minimum %0d", ACC_WL, acc_min_wl(WL, N));
  end

  state_e                    state_q, state_d;
  logic signed [ACC_WL-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic                      prod_vld_q, prod_vld_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [WL-1:0]      out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;

  logic signed [ACC_WL-1:0]  bias_ext;
  logic signed [ACC_WL-1:0]  prod_ext;
  logic signed [WL-1:0]      rs_data;
  logic                      rs_sat;

  assign bias_ext = ACC_WL'(bias);
  assign prod_ext = ACC_WL'(prod_q);

  round_sat #(
    .ACC_WL (ACC_WL),
    .WL     (WL),
    .FL     (FL)
  ) u_round_sat (
    .acc      (acc_q),
    .out_data (rs_data),
    .out_sat  (rs_sat)
  );

  // Next-state and datapath: multiply stage feeds the accumulate stage so
  // a new pair can be taken every cycle; DRAIN absorbs the last product.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    prod_vld_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    // A pending product is always folded in on the following edge
    if (prod_vld_q) begin
      acc_d = acc_q + prod_ext;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias_ext <<< FL;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          prod_d     = PROD_W'(x_in) * PROD_W'(w_in);
          prod_vld_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = ROUND;
      end
      ROUND: begin
        out_data_d  = rs_data;
        out_sat_d   = rs_sat;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_gate_preact_mac.sv
// Directed bench for gate_preact_mac: vector table run back to back, then
// handshake, start-pulse, gap and mid-operation reset sequences.
module tb_gate_preact_mac;

  localparam int WL     = 16;
  localparam int FL     = 8;
  localparam int N      = 8;
  localparam int ACC_WL = 40;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 start     = 1'b0;
  logic signed [WL-1:0] bias      = '0;
  logic                 in_valid  = 1'b0;
  logic signed [WL-1:0] x_in      = '0;
  logic signed [WL-1:0] w_in      = '0;
  logic                 out_ready = 1'b0;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [WL-1:0] out_data;
  logic                 out_sat;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  gate_preact_mac #(
    .WL     (WL),
    .FL     (FL),
    .N      (N),
    .ACC_WL (ACC_WL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .w_in      (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [WL-1:0]  bias;
    logic [N-1:0][WL-1:0]  x;
    logic [N-1:0][WL-1:0]  w;
    logic signed [WL-1:0]  exp_data;
    logic                  exp_sat;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t uni(input int b, input int xv, input int wv,
                               input int ed, input bit es);
    vec_t v;
    v.bias = WL'(b);
    for (int i = 0; i < N; i++) begin
      v.x[i] = WL'(xv);
      v.w[i] = WL'(wv);
    end
    v.exp_data = WL'(ed);
    v.exp_sat  = es;
    return v;
  endfunction

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One complete operation starting at the current negedge.
  task automatic run_op(input vec_t v, input bit gaps, input bit pulse_start,
                        input bit pre_ready, input int hold_cycles, input string tag);
    int edges;
    int i;
    int guard;
    bit acc;
    bit stable;
    logic signed [WL-1:0] d0;
    logic s0;

    bias      = v.bias;
    start     = 1'b1;
    out_ready = pre_ready;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    check({tag, ".busy_after_start"}, busy, 1);

    i = 0;
    guard = 0;
    while (i < N && guard < 200) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      x_in     = v.x[i];
      w_in     = v.w[i];
      start    = pulse_start;
      acc      = in_valid && in_ready;
      @(negedge clk);
      edges++;
      guard++;
      if (acc) i++;
    end
    in_valid = 1'b0;
    x_in     = '0;
    w_in     = '0;
    start    = 1'b0;
    check({tag, ".pairs_accepted"}, i, N);

    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      edges++;
      guard++;
    end
    check({tag, ".out_valid_seen"}, out_valid, 1);
    if (!gaps) check({tag, ".latency_edges"}, edges, N + 3);

    d0 = out_data;
    s0 = out_sat;
    check({tag, ".out_data"}, out_data, v.exp_data);
    check({tag, ".out_sat"}, out_sat, v.exp_sat);

    stable = 1'b1;
    for (int k = 0; k < hold_cycles; k++) begin
      start = pulse_start;
      @(negedge clk);
      if (out_data !== d0 || out_sat !== s0 || out_valid !== 1'b1) stable = 1'b0;
    end
    if (hold_cycles > 0) check({tag, ".held_stable"}, stable, 1);

    // Handshake cycle; a start here must be ignored since state is OUT
    out_ready = 1'b1;
    start     = pulse_start;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check({tag, ".valid_cleared"}, out_valid, 0);
    check({tag, ".idle_after_hs"}, busy, 0);
    $display("op %-10s bias=%0d out_data=%0d out_sat=%0d edges=%0d", tag, v.bias, d0, s0, edges);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1.0*1.0 eight times -> 8.0
    vecs[0] = uni(0, 256, 256, 2048, 1'b0);
    // 1*128 raw = 0.5 LSB -> rounds up to 1
    vecs[1] = uni(0, 0, 0, 1, 1'b0);
    vecs[1].x[0] = WL'(1);
    vecs[1].w[0] = WL'(128);
    // -0.5 LSB -> rounds up to 0
    vecs[2] = uni(0, 0, 0, 0, 1'b0);
    vecs[2].x[0] = WL'(1);
    vecs[2].w[0] = WL'(-128);
    // Positive and negative saturation
    vecs[3] = uni(0, 32767, 32767, 32767, 1'b1);
    vecs[4] = uni(0, -32768, 32767, -32768, 1'b1);
    // Bias only: -1.0
    vecs[5] = uni(-256, 0, 0, -256, 1'b0);
    // 1.0 + 8*(2.0*-0.5) = -7.0
    vecs[6] = uni(256, 512, -128, -1792, 1'b0);
    // bias 10 raw (2560 in acc) + 100*(1+..+8)=3600 -> 6160 -> 24.06 -> 24
    vecs[7] = uni(10, 0, 100, 24, 1'b0);
    for (int i = 0; i < N; i++) vecs[7].x[i] = WL'(i + 1);

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.out_valid", out_valid, 0);
    check("reset.in_ready", in_ready, 0);
    check("reset.busy", busy, 0);
    check("reset.out_data", out_data, 0);
    check("reset.out_sat", out_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table, back to back: each start lands one edge after the prior handshake
    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v], 1'b0, 1'b0, 1'b0, 0, $sformatf("vec%0d", v));
    end

    // Multi-cycle corner cases
    run_op(vecs[6], 1'b1, 1'b0, 1'b0, 0, "gaps6");
    run_op(vecs[7], 1'b1, 1'b0, 1'b0, 0, "gaps7");
    run_op(vecs[0], 1'b0, 1'b0, 1'b0, 5, "hold5");
    run_op(vecs[7], 1'b0, 1'b1, 1'b0, 3, "pulse");
    run_op(vecs[3], 1'b0, 1'b0, 1'b1, 0, "preready");

    // Reset after 4 of 8 pairs; the held 32767/sat result must also clear
    bias  = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      x_in     = WL'(256);
      w_in     = WL'(256);
      @(negedge clk);
    end
    in_valid = 1'b0;
    x_in     = '0;
    w_in     = '0;
    rst_n    = 1'b0;
    #1;
    check("midrst.out_valid", out_valid, 0);
    check("midrst.in_ready", in_ready, 0);
    check("midrst.busy", busy, 0);
    check("midrst.out_data", out_data, 0);
    check("midrst.out_sat", out_sat, 0);
    $display("op %-10s reset asserted after 4 pairs", "midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(vecs[1], 1'b0, 1'b0, 1'b0, 0, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_preact_mac.md
# gate_preact_mac

Sequential multiply-accumulate engine that computes one LSTM gate pre-activation, bias + Σ x[i]·w[i] over N element pairs, in signed fixed point. It sits directly upstream of the piecewise-linear sigmoid/tanh activation stage. It rounds and saturates the wide accumulator back to WL bits and presents the result on a valid/ready output; out_data drives the activation's sig_in.

## Interface
- WL, 16: data word length; all data ports are signed two's complement, Q(WL-FL).FL.
- FL, 8: fractional bits of x, w, bias and out_data.
- N, 8: pairs per dot product; N ≥ 1.
- ACC_WL, 40: accumulator width; must be ≥ 2·WL + clog2(N) + 1. Elaboration error otherwise.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a new dot product; honoured only in IDLE.
- bias  in  WL  gate bias, sampled on the start edge.
- in_valid  in  1  x/w pair valid.
- in_ready  out  1  pair accepted when in_valid && in_ready.
- x_in  in  WL  input/hidden element.
- w_in  in  WL  weight element.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WL  rounded, saturated pre-activation.
- out_sat  out  1  out_data was clipped; qualified by out_valid.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, ACCUM, DRAIN, ROUND, OUT.
- IDLE: start=1 → acc ← sign_ext(bias) <<< FL, cnt ← 0, go ACCUM. start is ignored in every other state.
- ACCUM: in_ready=1.
  - Each accepted pair loads prod_reg ← x_in·w_in (2·WL signed, Q.2FL), sets prod_vld and increments cnt.
  - When prod_vld is set, each edge adds acc += sign_ext(prod_reg). Multiply and add overlap, so one pair is accepted per cycle.
  - When the N-th pair is accepted, go DRAIN. in_ready is low from the next cycle.
- DRAIN: final acc += prod_reg, go ROUND.
- ROUND: r = (acc + 2^(FL-1)) >>> FL, arithmetic, round-half-up.
  - If r > 2^(WL-1)-1: out_data = max, out_sat=1.
  - If r < -2^(WL-1): out_data = min, out_sat=1.
  - Otherwise out_data = r[WL-1:0], out_sat=0.
  - Register the result, set out_valid, go OUT.
- OUT: hold out_data/out_sat stable. On out_ready=1, clear out_valid and go IDLE.
- in_valid gaps in ACCUM stall the count and do not change acc once prod_reg has drained.
- No overflow can occur inside acc, given the ACC_WL rule.
- Reset values, including mid-operation: state=IDLE, acc=0, cnt=0, prod_vld=0, in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0. A partial sum is discarded.

## Timing
- start sampled at edge S; in_ready high from the cycle after S.
- With in_valid held high, pairs are accepted on edges S+1 … S+N.
- Let E be the edge that accepts the N-th pair.
  - acc is final after E+1.
  - out_valid rises after E+2.
- Minimum start-to-out_valid: N+3 edges.
- Output handshake completes on the edge where out_valid && out_ready. State is IDLE after that edge.
- The earliest next start is sampled one edge later. There is no back-to-back overlap.
- out_ready held high before out_valid has no effect.
- start asserted in the same cycle as the output handshake is ignored, because state is still OUT.

## Structure
- Shared package lstm_pkg holds:
  - the state enum (IDLE, ACCUM, DRAIN, ROUND, OUT);
  - default WL/FL constants;
  - the ACC_WL minimum-width function.
- The activation stage reuses the same package.
- One sub-module, round_sat, is natural. It is combinational, with parameters ACC_WL, WL, FL. Input is acc; outputs are out_data and out_sat. Later stages (cell-state update, h output) reuse it.

## Test plan
- Basic sum: N=8, bias=0, x=256, w=256 (1.0·1.0) every cycle → out_data=2048 (8.0), out_sat=0, out_valid after E+2.
- Rounding: bias=0, one pair x=1,w=128 with the remaining seven zero → 1 (0.5 rounds up). Same with w=-128 → 0 (-0.5 rounds up to 0).
- Saturation: all pairs x=32767,w=32767 → out_data=32767, out_sat=1. All pairs x=-32768,w=32767 → out_data=-32768, out_sat=1. bias=-256 (-1.0) with zero pairs → -256, out_sat=0.
- Handshake:
  - Random in_valid gaps → same result as the gap-free run.
  - out_ready low for 5 cycles → out_data stable.
  - start pulses during ACCUM/OUT are ignored.
  - The next start is accepted one cycle after the handshake.
- Reset mid-operation: rst_n low after 4 of 8 pairs → all outputs 0 immediately. Then a new start computes a clean result with no residue from the partial sum.
